// File: rtl/dot_product_sched_pkg.sv
// Shared constants for the time-multiplexed dot-product scheduler:
// FSM state codes and width helpers for the channel index and accumulator.
package dot_product_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_EMIT  = 2'd3;

    // Index width for a range of n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Full-precision product / accumulator width for W-bit operands.
    function automatic int acc_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/dot_product_scheduler_mac_unit.sv
// Shared multiply-accumulate datapath: a registered product feeding a
// wrapping accumulator. clear zeroes both, step issues one multiply and
// folds the previous product in, flush folds the final product into acc.
// Optional build macro RELU_EN clamps a negative sum to zero on o_sum.
module mac_unit
    import dot_product_sched_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_clear,
    input  logic                           i_step,
    input  logic                           i_flush,
    input  logic signed [W-1:0]            i_a,
    input  logic signed [W-1:0]            i_w,
    output logic signed [acc_width(W)-1:0] o_sum
);

    localparam int AW = acc_width(W);

    logic signed [AW-1:0] r_prod;
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_prod;
    logic signed [AW-1:0] w_raw;

    // Operands are sign-extended before the multiply so the product is exact.
    assign w_prod = AW'(i_a) * AW'(i_w);
    assign w_raw  = r_acc + r_prod;

`ifdef RELU_EN
    assign o_sum = w_raw[AW-1] ? '0 : w_raw;
`else
    assign o_sum = w_raw;
`endif

    // Product/accumulator pipeline; the sum wraps modulo 2^AW.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values and r_acc picks up the old r_prod.
        if (rst || i_clear) begin
            r_prod <= '0;
            r_acc  <= '0;
        end else if (i_step) begin
            r_prod <= w_prod;
            r_acc  <= w_raw;
        end else if (i_flush) begin
            r_acc  <= w_raw;
            r_prod <= '0;
        end
    end

endmodule

// File: rtl/dot_product_scheduler.sv
// Dot-product scheduler: accepts one activation vector, then walks a single
// MAC over C weight rows, emitting one valid/ready result per channel.
// Weight table WEIGHTS is flattened row-major: entry c*D+i at bits
// [(c*D+i)*W +: W]. Optional build macro RELU_EN (applied in mac_unit).
module dot_product_scheduler
    import dot_product_sched_pkg::*;
#(
    parameter int               W       = 16,
    parameter int               D       = 16,
    parameter int               C       = 4,
    parameter logic [C*D*W-1:0] WEIGHTS = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [D*W-1:0]                 packed_a,
    input  logic                           in_v,
    output logic                           in_rdy,
    output logic signed [acc_width(W)-1:0] out,
    output logic [clog2_min1(C)-1:0]       out_ch,
    output logic                           out_last,
    output logic                           out_v,
    input  logic                           out_rdy,
    output logic                           busy
);

    localparam int CW = clog2_min1(C);
    localparam int DW = clog2_min1(D);
    localparam int IW = clog2_min1(C * D);
    localparam int AW = acc_width(W);

    logic [1:0]           r_state;
    logic [D*W-1:0]       r_a;
    logic [CW-1:0]        r_c;
    logic [DW-1:0]        r_i;

    logic signed [W-1:0]  w_rom   [C*D];
    logic signed [W-1:0]  w_a_vec [D];
    logic [IW-1:0]        w_idx;
    logic signed [W-1:0]  w_a_elem;
    logic signed [W-1:0]  w_weight;
    logic signed [AW-1:0] w_sum;
    logic                 w_accept;
    logic                 w_emit_done;
    logic                 w_last_c;
    logic                 w_last_i;
    logic                 w_clear;
    logic                 w_step;
    logic                 w_flush;

    // Unpack the weight table and captured vector into indexable arrays.
    for (genvar k = 0; k < C * D; k++) begin : g_rom
        assign w_rom[k] = WEIGHTS[k*W +: W];
    end
    for (genvar j = 0; j < D; j++) begin : g_avec
        assign w_a_vec[j] = r_a[W*(D-j-1) +: W];
    end

    assign in_rdy = (r_state == ST_IDLE);
    assign busy   = (r_state != ST_IDLE);

    // Operand selection and per-cycle datapath control strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        w_idx       = IW'(int'(r_c) * D + int'(r_i));
        w_a_elem    = w_a_vec[r_i];
        w_weight    = w_rom[w_idx];
        w_accept    = 1'b0;
        w_emit_done = 1'b0;
        w_step      = 1'b0;
        w_flush     = 1'b0;
        w_last_c    = (r_c == CW'(C - 1));
        w_last_i    = (r_i == DW'(D - 1));
        case (r_state)
            ST_IDLE:  w_accept    = in_v;
            ST_MAC:   w_step      = 1'b1;
            ST_FLUSH: w_flush     = 1'b1;
            ST_EMIT:  w_emit_done = out_rdy;
            default:  ;
        endcase
        w_clear = w_accept || (w_emit_done && !w_last_c);
    end

    mac_unit #(.W(W)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_step  (w_step),
        .i_flush (w_flush),
        .i_a     (w_a_elem),
        .i_w     (w_weight),
        .o_sum   (w_sum)
    );

    // Input capture; the held copy isolates the MAC from later packed_a changes.
    always_ff @(posedge clk) begin
        // NOTE: r_a is deliberately left out of reset; it is only read after
        // a fresh capture, so clearing it would only add reset fan-out.
        if (w_accept) begin
            r_a <= packed_a;
        end
    end

    // Scheduler FSM, channel/element counters and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_c      <= '0;
            r_i      <= '0;
            out      <= '0;
            out_ch   <= '0;
            out_last <= 1'b0;
            out_v    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_v) begin
                        r_c     <= '0;
                        r_i     <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_i <= w_last_i ? '0 : r_i + DW'(1);
                    if (w_last_i) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    out      <= w_sum;
                    out_ch   <= r_c;
                    out_last <= w_last_c;
                    out_v    <= 1'b1;
                    r_state  <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_rdy) begin
                        out_v <= 1'b0;
                        if (w_last_c) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_c     <= r_c + CW'(1);
                            r_i     <= '0;
                            r_state <= ST_MAC;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Self-checking bench for dot_product_scheduler: a W=16/D=4/C=2 instance
// with weight rows {1,2,3,4} and {-1,-1,-1,-1}, plus a W=8/D=4/C=1 instance
// with all weights 127 for the wrap case. Expected results come from a
// plain-arithmetic dot-product model (ReLU applied when RELU_EN is defined).
module tb_dot_product_scheduler;

    localparam int W0 = 16, D0 = 4, C0 = 2;
    localparam int W1 = 8,  D1 = 4, C1 = 1;
    localparam logic [C0*D0*W0-1:0] WTS0 = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                            16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [C1*D1*W1-1:0] WTS1 = {4{8'd127}};
`ifdef RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    int wt0 [C0][D0] = '{'{1, 2, 3, 4}, '{-1, -1, -1, -1}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0 signals
    logic [D0*W0-1:0]  packed_a0;
    logic              in_v0, in_rdy0, out_last0, out_v0, out_rdy0, busy0;
    logic signed [31:0] out0;
    logic [0:0]        out_ch0;

    // Instance 1 signals
    logic [D1*W1-1:0]  packed_a1;
    logic              in_v1, in_rdy1, out_last1, out_v1, out_rdy1, busy1;
    logic signed [15:0] out1;
    logic [0:0]        out_ch1;

    dot_product_scheduler #(.W(W0), .D(D0), .C(C0), .WEIGHTS(WTS0)) u_dut0 (
        .clk(clk), .rst(rst), .packed_a(packed_a0), .in_v(in_v0), .in_rdy(in_rdy0),
        .out(out0), .out_ch(out_ch0), .out_last(out_last0), .out_v(out_v0),
        .out_rdy(out_rdy0), .busy(busy0)
    );

    dot_product_scheduler #(.W(W1), .D(D1), .C(C1), .WEIGHTS(WTS1)) u_dut1 (
        .clk(clk), .rst(rst), .packed_a(packed_a1), .in_v(in_v1), .in_rdy(in_rdy1),
        .out(out1), .out_ch(out_ch1), .out_last(out_last1), .out_v(out_v1),
        .out_rdy(out_rdy1), .busy(busy1)
    );

    typedef struct {
        logic [31:0] d;
        logic        ch;
        logic        last;
    } res_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   e, g, n, pulses, got;
    logic [63:0] va, vb;
    logic [31:0] v1;
    res_t q_got[$];
    res_t q_exp[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] relu32(input logic [31:0] v);
        return (RELU && v[31]) ? 32'd0 : v;
    endfunction

    // Reference dot product for instance 0: exact sum, then wrap to 32 bits.
    function automatic logic [31:0] model0(input logic [63:0] a, input int ch);
        longint s = 0;
        for (int i = 0; i < D0; i++)
            s += longint'($signed(a[W0*(D0-1-i) +: W0])) * longint'(wt0[ch][i]);
        return relu32(s[31:0]);
    endfunction

    // Reference for instance 1: every weight is 127, result wraps to 16 bits.
    function automatic logic [15:0] model1(input logic [31:0] a);
        longint s = 0;
        logic [15:0] r;
        for (int i = 0; i < D1; i++)
            s += longint'($signed(a[W1*(D1-1-i) +: W1])) * 127;
        r = s[15:0];
        return (RELU && r[15]) ? 16'd0 : r;
    endfunction

    function automatic logic [63:0] rand_vec();
        return {$urandom(), $urandom()};
    endfunction

    // Present a vector to instance 0 once it is ready; returns at the negedge
    // after the accept edge, with packed_a scrambled to prove it was captured.
    task automatic send0(input logic [63:0] a);
        int k = 0;
        while (!in_rdy0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("send0_ready", in_rdy0, 1);
        packed_a0 = a;
        in_v0     = 1'b1;
        @(negedge clk);
        in_v0     = 1'b0;
        packed_a0 = ~a;
    endtask

    // Count edges until instance 0 shows out_v, bounded.
    task automatic wait_out0(output int edges);
        edges = 0;
        while (!out_v0 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("out0_valid", out_v0, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_v0 = 1'b0; out_rdy0 = 1'b0; packed_a0 = '0;
        in_v1 = 1'b0; out_rdy1 = 1'b0; packed_a1 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_out_v", out_v0, 0);
        check("rst_in_rdy", in_rdy0, 1);
        check("rst_busy", busy0, 0);
        check("rst_out", out0, 0);
        check("rst_out_ch", out_ch0, 0);
        check("rst_out_last", out_last0, 0);
        rst = 1'b0;

        // Directed: a={1,1,1,1}, out_rdy held high; latency counts the accept edge as 1
        out_rdy0 = 1'b1;
        va = {16'd1, 16'd1, 16'd1, 16'd1};
        send0(va);
        check("t1_in_rdy_low", in_rdy0, 0);
        check("t1_busy", busy0, 1);
        wait_out0(e);
        check("t1_latency_first", e + 1, D0 + 2);
        check("t1_ch0_out", out0, relu32(32'd10));
        check("t1_ch0_ch", out_ch0, 0);
        check("t1_ch0_last", out_last0, 0);
        @(negedge clk);
        check("t1_after_hs_out_v", out_v0, 0);
        wait_out0(g);
        check("t1_latency_next", g, D0 + 1);
        check("t1_ch1_out", out0, relu32(-32'sd4));
        check("t1_ch1_ch", out_ch0, 1);
        check("t1_ch1_last", out_last0, 1);
        @(negedge clk);
        check("t1_idle_busy", busy0, 0);
        check("t1_idle_in_rdy", in_rdy0, 1);

        // Back-pressure: out_rdy low for 5 cycles on the ch0 result
        out_rdy0 = 1'b0;
        send0(va);
        wait_out0(e);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold_v", out_v0, 1);
            check("t3_hold_out", out0, relu32(32'd10));
            check("t3_hold_ch", out_ch0, 0);
        end
        out_rdy0 = 1'b1;
        @(negedge clk);
        check("t3_hs_out_v", out_v0, 0);
        wait_out0(g);
        check("t3_ch1_after_hs", g, D0 + 1);
        check("t3_ch1_out", out0, relu32(-32'sd4));
        @(negedge clk);

        // Reset during the MAC of ch1 abandons the vector
        send0(va);
        wait_out0(e);
        check("t4_ch0_out", out0, relu32(32'd10));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_rst_out_v", out_v0, 0);
        check("t4_rst_in_rdy", in_rdy0, 1);
        check("t4_rst_busy", busy0, 0);
        check("t4_rst_out", out0, 0);
        va = {16'd2, 16'd0, 16'd0, 16'd0};
        send0(va);
        wait_out0(e);
        check("t4_new_ch0", out0, relu32(32'd2));
        @(negedge clk);
        wait_out0(e);
        check("t4_new_ch1", out0, relu32(-32'sd2));
        check("t4_new_last", out_last0, 1);
        @(negedge clk);

        // W=8, C=1: 4*127*127 = 64516 wraps to -1020
        packed_a1 = {4{8'd127}};
        in_v1 = 1'b1;
        out_rdy1 = 1'b1;
        @(negedge clk);
        in_v1 = 1'b0;
        n = 0;
        while (!out_v1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid", out_v1, 1);
        check("t5_wrap", {16'd0, out1}, {16'd0, (RELU ? 16'd0 : 16'hFC04)});
        check("t5_last", out_last1, 1);
        check("t5_ch", out_ch1, 0);
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            v1 = $urandom();
            packed_a1 = v1;
            in_v1 = 1'b1;
            @(negedge clk);
            in_v1 = 1'b0;
            n = 0;
            while (!out_v1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("t5_rand_valid", out_v1, 1);
            check("t5_rand_out", {16'd0, out1}, {16'd0, model1(v1)});
            @(negedge clk);
        end

        // in_v held high across two distinct vectors
        va = rand_vec();
        vb = rand_vec();
        check("t6_start_ready", in_rdy0, 1);
        q_got.delete();
        q_exp.delete();
        for (int v = 0; v < 2; v++)
            for (int c = 0; c < C0; c++)
                q_exp.push_back('{model0((v == 0) ? va : vb, c), c[0], (c == C0 - 1)});
        packed_a0 = va;
        in_v0 = 1'b1;
        out_rdy0 = 1'b1;
        pulses = 1;
        n = 0;
        while (q_got.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (out_v0) q_got.push_back('{out0, out_ch0, out_last0});
            if (in_rdy0 && in_v0) pulses++;
            else if (pulses == 1) packed_a0 = vb;
            else if (pulses == 2) in_v0 = 1'b0;
        end
        in_v0 = 1'b0;
        check("t6_rdy_pulses", pulses, 2);
        check("t6_count", q_got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < q_got.size()) begin
                check("t6_data", q_got[k].d, q_exp[k].d);
                check("t6_ch", q_got[k].ch, q_exp[k].ch);
                check("t6_last", q_got[k].last, q_exp[k].last);
            end
        end
        @(negedge clk);

        // Random vectors with random downstream stalls
        for (int r = 0; r < 8; r++) begin
            va = rand_vec();
            send0(va);
            got = 0;
            n = 0;
            while (got < C0 && n < 200) begin
                if (out_v0 && ($urandom_range(0, 1) == 1)) begin
                    check("t7_out", out0, model0(va, got));
                    check("t7_ch", out_ch0, got);
                    check("t7_last", out_last0, got == C0 - 1);
                    out_rdy0 = 1'b1;
                    got++;
                end else begin
                    out_rdy0 = out_v0 ? 1'b0 : 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                n++;
            end
            check("t7_done", got, C0);
            out_rdy0 = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
